// File: rtl/mem_responder.sv
// Fixed-latency word memory answering memory-stage bus requests with byte-strobed writes,
// an out-of-range error pulse and a sticky overrun flag for requests that arrive while busy.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request_enable,
  input  logic        mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        response_enable,
  output logic [31:0] data,
  output logic        error,
  output logic        overrun
);

  localparam int unsigned IW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          mode_q;
  logic          err_q;
  logic [31:0]   hold;

  logic [31:0]   offset;
  logic          in_range;
  logic [IW-1:0] word_index;
  logic          respond_now;
  logic          accept;
  logic [31:0]   rd_word;

  // BASE_ADDR is aligned to the span, so the low offset bits equal the low address bits.
  assign offset      = addr - BASE_ADDR;
  assign in_range    = ({1'b0, offset} < SPAN);
  assign word_index  = offset[IW+1:2];
  assign respond_now = (state == BUSY) && (cnt == 4'd0);
  assign accept      = request_enable && ((state == IDLE) || respond_now);

  // One byte-wide array per lane so each strobe maps to an independent write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (accept && mode && in_range && wstrb[gi]) begin
          mem[word_index] <= wdata[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = mem[word_index];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      mode_q          <= 1'b0;
      err_q           <= 1'b0;
      hold            <= 32'h0;
      response_enable <= 1'b0;
      data            <= 32'h0;
      error           <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      response_enable <= 1'b0;
      error           <= 1'b0;

      if (request_enable && !accept) begin
        overrun <= 1'b1;
      end

      if (respond_now) begin
        response_enable <= 1'b1;
        data            <= mode_q ? 32'h0 : hold;
        error           <= err_q;
        state           <= IDLE;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end

      // A request on the response edge overrides the return to IDLE.
      if (accept) begin
        state  <= BUSY;
        cnt    <= CNT_INIT;
        mode_q <= mode;
        err_q  <= !in_range;
        hold   <= (!mode && in_range) ? rd_word : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (latency 2 and latency 1) share one stimulus stream
// and are checked every cycle against a transaction-level model, plus directed literal checks.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        request_enable;
  logic        mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic [1:0]        resp_en;
  logic [1:0][31:0]  dout;
  logic [1:0]        err;
  logic [1:0]        ovr;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .request_enable(request_enable), .mode(mode), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .response_enable(resp_en[0]), .data(dout[0]),
    .error(err[0]), .overrun(ovr[0])
  );

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .request_enable(request_enable), .mode(mode), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .response_enable(resp_en[1]), .data(dout[1]),
    .error(err[1]), .overrun(ovr[1])
  );

  // ---------------- reference model ----------------
  int unsigned edge_no = 0;
  int unsigned ready_at [2];
  int unsigned due      [2];
  bit          pend     [2];
  logic [31:0] pend_data[2];
  bit [3:0]    pend_mask[2];
  bit          pend_err [2];
  bit          exp_re   [2];
  logic [31:0] exp_data [2];
  bit [3:0]    exp_mask [2];
  bit          exp_err  [2];
  bit          exp_ovr  [2];
  bit [31:0]   mmem [int unsigned];
  bit [3:0]    mdef [int unsigned];

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ready_at[k] = 0; due[k] = 0; pend[k] = 1'b0;
      pend_data[k] = 32'h0; pend_mask[k] = 4'hF; pend_err[k] = 1'b0;
      exp_re[k] = 1'b0; exp_data[k] = 32'h0; exp_mask[k] = 4'hF;
      exp_err[k] = 1'b0; exp_ovr[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int unsigned key;
    bit hit;
    if (rst) begin
      model_reset();
    end else begin
      edge_no++;
      for (int k = 0; k < 2; k++) begin
        exp_re[k]  = 1'b0;
        exp_err[k] = 1'b0;
        if (pend[k] && due[k] == edge_no) begin
          exp_re[k]   = 1'b1;
          exp_data[k] = pend_data[k];
          exp_mask[k] = pend_mask[k];
          exp_err[k]  = pend_err[k];
          pend[k]     = 1'b0;
        end
        if (request_enable) begin
          if (edge_no >= ready_at[k]) begin
            hit         = (addr < 32'h1000);
            key         = k * 4096 + int'(addr[11:2]);
            pend[k]     = 1'b1;
            due[k]      = edge_no + lat_of(k);
            ready_at[k] = due[k];
            pend_err[k] = !hit;
            pend_data[k] = 32'h0;
            pend_mask[k] = 4'hF;
            if (!mode && hit) begin
              pend_data[k] = mmem.exists(key) ? mmem[key] : 32'h0;
              pend_mask[k] = mdef.exists(key) ? mdef[key] : 4'h0;
            end else if (mode && hit) begin
              if (!mmem.exists(key)) begin mmem[key] = 32'h0; mdef[key] = 4'h0; end
              for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                  mmem[key][8*i +: 8] = wdata[8*i +: 8];
                  mdef[key][i] = 1'b1;
                end
              end
            end
          end else begin
            exp_ovr[k] = 1'b1;
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) model_edge();

  // ---------------- checking ----------------
  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%h expected=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [31:0] m;
    for (int k = 0; k < 2; k++) begin
      m = {{8{exp_mask[k][3]}}, {8{exp_mask[k][2]}}, {8{exp_mask[k][1]}}, {8{exp_mask[k][0]}}};
      chk("response_enable", k, {31'h0, resp_en[k]}, {31'h0, exp_re[k]});
      chk("error", k, {31'h0, err[k]}, {31'h0, exp_err[k]});
      chk("overrun", k, {31'h0, ovr[k]}, {31'h0, exp_ovr[k]});
      chk("data", k, dout[k] & m, exp_data[k] & m);
    end
  endtask

  always @(negedge clk) if (cmp_on) compare_all();

  // ---------------- stimulus helpers ----------------
  task automatic req_now(input bit m, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    request_enable = 1'b1; mode = m; addr = a; wdata = wd; wstrb = ws;
    @(posedge clk); #1;
    request_enable = 1'b0;
  endtask

  task automatic issue(input bit m, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    @(posedge clk); #1;
    req_now(m, a, wd, ws);
  endtask

  task automatic wait_resp(input int k, output int lat, output logic [31:0] d, output logic e);
    lat = -1; d = 32'h0; e = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (resp_en[k]) begin lat = c; d = dout[k]; e = err[k]; break; end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL resp_timeout inst%0d actual=none required=response within 20 cycles", k);
    end
  endtask

  task automatic count_resp(input int k, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (resp_en[k]) cnt++;
    end
  endtask

  // ---------------- directed + random test ----------------
  initial begin
    int lat, n0, n1;
    logic [31:0] d;
    logic e;

    rst = 1'b1; request_enable = 1'b0; mode = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    model_reset();
    #1 cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // full-word write then read
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_resp(0, lat, d, e);
    chk("wr_data", 0, d, 32'h0);
    chk("wr_err", 0, {31'h0, e}, 32'h0);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_resp(0, lat, d, e);
    chk("rd_latency", 0, lat, 2);
    chk("rd_data", 0, d, 32'hDEADBEEF);
    chk("rd_err", 0, {31'h0, e}, 32'h0);

    // byte strobes, read through an unaligned alias
    issue(1'b1, 32'h10, 32'h0011_0000, 4'b0100);
    wait_resp(0, lat, d, e);
    issue(1'b1, 32'h10, 32'h0000_2233, 4'b0011);
    wait_resp(0, lat, d, e);
    issue(1'b0, 32'h13, 32'h0, 4'h0);
    wait_resp(0, lat, d, e);
    chk("strobe_data", 0, d, 32'hDE112233);

    // out of range
    issue(1'b1, 32'h0, 32'h12345678, 4'hF);  wait_resp(0, lat, d, e);
    issue(1'b1, 32'h4, 32'hCAFEF00D, 4'hF);  wait_resp(0, lat, d, e);
    issue(1'b1, 32'h8, 32'h0BADC0DE, 4'hF);  wait_resp(0, lat, d, e);
    issue(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    wait_resp(0, lat, d, e);
    chk("oor_wr_err", 0, {31'h0, e}, 32'h1);
    chk("oor_wr_data", 0, d, 32'h0);
    issue(1'b0, 32'h1000, 32'h0, 4'h0);
    wait_resp(0, lat, d, e);
    chk("oor_rd_err", 0, {31'h0, e}, 32'h1);
    chk("oor_rd_data", 0, d, 32'h0);
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    wait_resp(0, lat, d, e);
    chk("word0_kept", 0, d, 32'h12345678);

    // overrun: second request one cycle after the first
    chk("ovr_before", 0, {31'h0, ovr[0]}, 32'h0);
    @(posedge clk); #1;
    request_enable = 1'b1; mode = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    addr = 32'h4;
    @(posedge clk); #1;
    request_enable = 1'b0;
    count_resp(0, 8, n0);
    chk("ovr_resp_count", 0, n0, 1);
    chk("ovr_sticky", 0, {31'h0, ovr[0]}, 32'h1);
    chk("ovr_l1_clear", 1, {31'h0, ovr[1]}, 32'h0);

    // asynchronous reset mid-cycle
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_resp", k, {31'h0, resp_en[k]}, 32'h0);
      chk("rst_data", k, dout[k], 32'h0);
      chk("rst_err", k, {31'h0, err[k]}, 32'h0);
      chk("rst_ovr", k, {31'h0, ovr[k]}, 32'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n0 = 0; n1 = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (resp_en[0]) n0++;
      if (resp_en[1]) n1++;
    end
    chk("quiet_after_rst", 0, n0, 0);
    chk("quiet_after_rst", 1, n1, 0);

    // back-to-back reads on the latency-1 instance
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    wait_resp(1, lat, d, e);
    chk("b2b_lat", 1, lat, 1);
    chk("b2b_w0", 1, d, 32'h12345678);
    req_now(1'b0, 32'h4, 32'h0, 4'h0);
    wait_resp(1, lat, d, e);
    chk("b2b_w1", 1, d, 32'hCAFEF00D);
    req_now(1'b0, 32'h8, 32'h0, 4'h0);
    wait_resp(1, lat, d, e);
    chk("b2b_w2", 1, d, 32'h0BADC0DE);
    chk("b2b_ovr", 1, {31'h0, ovr[1]}, 32'h0);

    // randomized traffic with occasional resets
    repeat (3000) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 299) == 0) begin
        request_enable = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        request_enable = ($urandom_range(0, 99) < 45);
        mode  = $urandom_range(0, 1) == 1;
        wdata = $urandom;
        wstrb = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 7))
          0:       addr = 32'h1000 + 32'($urandom_range(0, 63));
          1:       addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
          2:       addr = 32'hFFC + 32'($urandom_range(0, 3));
          default: addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        endcase
      end
    end
    @(posedge clk); #1;
    request_enable = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
